seq_bist_tester: RTL and testbench
==================================

# seq_bist_tester

Built-in self-test harness for the generic sequential benchmark circuits (3-bit input, 6-bit output, async active-low reset).
- Drives pseudo-random stimulus into a circuit under test (CUT).
- Compacts the CUT's responses into a 16-bit MISR signature.
- Compares the signature against a golden value.
- Serves as the stimulus/response end of the benchmark interface, used to detect trojan-induced deviations between golden and suspect netlists.

## Interface
- `N_PATTERNS`, default 256: number of stimulus patterns applied per run (≥1).
- `LFSR_SEED`, default 8'hA5: stimulus LFSR seed. Zero is replaced by 8'h01.
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-low reset.
- `start  in  1`: run request, sampled in IDLE/DONE.
- `golden_sig  in  16`: expected signature, sampled in DONE.
- `dut_out  in  6`: CUT response.
- `dut_in  out  3`: CUT stimulus.
- `dut_reset  out  1`: active-low reset to CUT.
- `busy  out  1`: run in progress.
- `done  out  1`: run complete, result valid.
- `pass  out  1`: signature equals `golden_sig`, valid only while `done`=1.
- `signature  out  16`: MISR contents.

## Operation
- FSM states: IDLE, INIT, APPLY, FLUSH, DONE.
- IDLE: `start`=1 → INIT.
- INIT (1 cycle):
  - `dut_reset`=0.
  - LFSR ← seed; MISR ← 0; pattern counter ← 0.
  - → APPLY.
- APPLY (exactly `N_PATTERNS` cycles):
  - `dut_in` = `lfsr[2:0]`.
  - At each edge:
    - LFSR shifts: `lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
    - MISR samples `dut_out`.
    - Counter increments.
  - Counter reaching `N_PATTERNS`-1 → FLUSH.
- FLUSH (1 cycle):
  - `dut_in`=0.
  - MISR samples `dut_out` once more, capturing the response to the last pattern.
  - → DONE.
- MISR update: `misr ← {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ {10'b0, dut_out}`. Total samples per run: `N_PATTERNS`+1.
- DONE:
  - `done`=1.
  - `pass` = (`signature` == `golden_sig`), combinational on the current `golden_sig`.
  - Holds until `start`=1 → INIT. That restart clears `done`.
- `start` in INIT/APPLY/FLUSH is ignored.
- `dut_reset`=1 in all states except INIT.
- `dut_in`=0 outside APPLY.
- `busy`=1 in INIT, APPLY and FLUSH.
- `signature` = MISR register at all times.
- Counter width: `$clog2(N_PATTERNS+1)`.
- `N_PATTERNS`=1: APPLY lasts one cycle.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE.
  - `busy`=0, `done`=0, `pass`=0, `signature`=0, `dut_in`=0, `dut_reset`=1.
  - LFSR=seed.
- Reset mid-run: immediate return to IDLE with the reset values above. No partial result is retained.
- `start` sampled at edge t:
  - `busy` rises after edge t.
  - `done` rises after edge t+`N_PATTERNS`+2.
  - Total run length: `N_PATTERNS`+2 busy cycles.
- The CUT sees stimulus k during APPLY cycle k. Its response appears on `dut_out` in the following cycle, which the FLUSH sample accounts for.

## Structure
- Package `bist_pkg` holds:
  - State enum.
  - LFSR tap mask, MISR polynomial 16'h1021.
  - Constants `STIM_W`=3, `RESP_W`=6, `SIG_W`=16.
- Sub-module `bist_misr`: 16-bit MISR with clear/enable. Instantiated once.
- LFSR, counter and FSM live in the top level.

## Test plan
All scenarios use the generic XOR-state benchmark as CUT unless stated.
- Golden run, `N_PATTERNS`=4, `LFSR_SEED`=8'h01:
  - `dut_in` sequence 1,2,4,0.
  - MISR samples 0,1,3,7,7.
  - `signature`=16'h000D.
  - `golden_sig`=16'h000D → `pass`=1.
  - `done` rises 6 edges after `start`.
- Same configuration with `golden_sig`=16'h000C → `done`=1, `pass`=0.
- Fault injection: force `dut_out[0]`=0 → `signature`≠16'h000D, `pass`=0.
- Timing checks:
  - `start` pulsed during APPLY → ignored. Run length and signature are unchanged.
  - `start` in DONE → identical second run, same signature.
- Async reset:
  - Deassert `reset` mid-APPLY → outputs go to reset values within the same cycle. State is IDLE.
  - A subsequent `start` reproduces 16'h000D.
- Default parameters (256 patterns, seed 8'hA5) against the golden CUT and then a trojaned copy → signatures differ. `pass` tracks the stored golden value.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types, constants and step functions for the sequential-benchmark BIST harness.
package bist_pkg;

    localparam int STIM_W = 3;
    localparam int RESP_W = 6;
    localparam int SIG_W  = 16;
    localparam int LFSR_W = 8;

    // Feedback taps on bits 7,5,4,3 of the stimulus LFSR.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_APPLY = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0]  cur,
                                                   input logic [RESP_W-1:0] resp);
        return {cur[SIG_W-2:0], 1'b0}
             ^ (cur[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}})
             ^ {{(SIG_W-RESP_W){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/seq_bist_tester_if.sv
// Control and CUT-facing signal bundle of the BIST harness.
interface seq_bist_tester_if;
    import bist_pkg::*;

    logic              start;
    logic [SIG_W-1:0]  golden_sig;
    logic [RESP_W-1:0] dut_out;
    logic [STIM_W-1:0] dut_in;
    logic              dut_reset;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;

    modport master (
        output start, golden_sig, dut_out,
        input  dut_in, dut_reset, busy, done, pass, signature
    );

    modport slave (
        input  start, golden_sig, dut_out,
        output dut_in, dut_reset, busy, done, pass, signature
    );

endinterface

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with clear and sample enable.
module bist_misr
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] misr_r;

    // Signature register; clear takes priority over sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misr_r <= {SIG_W{1'b0}};
        end else if (clr) begin
            misr_r <= {SIG_W{1'b0}};
        end else if (en) begin
            misr_r <= misr_step(misr_r, din);
        end else begin
            misr_r <= misr_r;
        end
    end

    assign sig = misr_r;

endmodule

// File: rtl/seq_bist_tester.sv
// BIST harness: LFSR stimulus into a sequential CUT, MISR compaction of its
// responses and comparison of the final signature against a golden value.
module seq_bist_tester
    import bist_pkg::*;
#(
    parameter int                N_PATTERNS = 256,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    seq_bist_tester_if.slave bus
);

    localparam int                CNT_W    = $clog2(N_PATTERNS + 1);
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_PATTERNS - 1);

    bist_state_e       state_r;
    bist_state_e       state_nxt_s;
    logic [LFSR_W-1:0] lfsr_r;
    logic [LFSR_W-1:0] lfsr_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              misr_clr_s;
    logic              misr_en_s;
    logic [SIG_W-1:0]  sig_s;
    logic              busy_r;
    logic              done_r;
    logic              dut_reset_r;
    logic [STIM_W-1:0] dut_in_r;

    // Next-state, LFSR/counter update and MISR strobes.
    always_comb begin
        state_nxt_s = state_r;
        lfsr_nxt_s  = lfsr_r;
        cnt_nxt_s   = cnt_r;
        misr_clr_s  = 1'b0;
        misr_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                state_nxt_s = ST_APPLY;
                lfsr_nxt_s  = SEED_EFF;
                cnt_nxt_s   = {CNT_W{1'b0}};
                misr_clr_s  = 1'b1;
            end
            ST_APPLY: begin
                lfsr_nxt_s = lfsr_step(lfsr_r);
                cnt_nxt_s  = cnt_r + CNT_W'(1);
                misr_en_s  = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_APPLY;
                end
            end
            ST_FLUSH: begin
                // One extra sample catches the CUT's answer to the last pattern.
                misr_en_s   = 1'b1;
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, stimulus generator, pattern counter and outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= SEED_EFF;
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dut_reset_r <= 1'b1;
            dut_in_r    <= {STIM_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            lfsr_r      <= lfsr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_APPLY) ||
                           (state_nxt_s == ST_FLUSH);
            done_r      <= (state_nxt_s == ST_DONE);
            dut_reset_r <= (state_nxt_s != ST_INIT);
            dut_in_r    <= (state_nxt_s == ST_APPLY) ? lfsr_nxt_s[STIM_W-1:0]
                                                     : {STIM_W{1'b0}};
        end
    end

    bist_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (misr_clr_s),
        .en    (misr_en_s),
        .din   (bus.dut_out),
        .sig   (sig_s)
    );

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.dut_reset = dut_reset_r;
    assign bus.dut_in    = dut_in_r;
    assign bus.signature = sig_s;
    // Follows golden_sig combinationally so a late golden value is still judged.
    assign bus.pass      = done_r & (sig_s == bus.golden_sig);

endmodule

// File: tb/tb_seq_bist_tester.sv
// Self-checking bench: two harness instances (4-pattern/seed 01 and defaults) driving
// an XOR-state CUT, checked every cycle against a run-timeline reference model.
module tb_seq_bist_tester;
    import bist_pkg::*;

    localparam int        NP0   = 4;
    localparam logic [7:0] SEED0 = 8'h01;
    localparam int        NP1   = 256;
    localparam logic [7:0] SEED1 = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [15:0] gold_v [2];
    int          mode_v [2];   // 0 golden CUT, 1 dut_out[0] stuck at 0, 2 trojaned CUT
    logic [1:0]  busy_v, done_v, pass_v, dutrst_v;
    logic [2:0]  din_v [2];
    logic [15:0] sig_v [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [5:0] cut_resp(input logic [5:0] st, input int mode);
        logic [5:0] r = st;
        if (mode == 1) r[0] = 1'b0;
        else if (mode == 2) r[5] = st[0] & st[2];
        return r;
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] misr_fold(input logic [15:0] m, input logic [5:0] d);
        logic [15:0] p = m[15] ? 16'h1021 : 16'h0000;
        return {m[14:0], 1'b0} ^ p ^ {10'b0, d};
    endfunction

    function automatic logic [2:0] stim_at(input logic [7:0] seed, input int k);
        logic [7:0] v = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < k; i++) v = lfsr_adv(v);
        return v[2:0];
    endfunction

    // Expected final signature: n+1 samples of the CUT response, CUT absorbing stimulus k after sample k.
    function automatic logic [15:0] run_sig(input logic [7:0] seed, input int n, input int mode);
        logic [5:0]  st = 6'd0;
        logic [15:0] m  = 16'h0000;
        for (int k = 0; k <= n; k++) begin
            m = misr_fold(m, cut_resp(st, mode));
            if (k < n) st = st ^ {3'b000, stim_at(seed, k)};
        end
        return m;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h time=%0t", name, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int         NP   = (g == 0) ? NP0 : NP1;
        localparam logic [7:0] SEED = (g == 0) ? SEED0 : SEED1;

        seq_bist_tester_if bus ();
        logic [5:0]  cut_st = 6'd0;
        int          pos_m  = -1;   // -1 idle, 0..NP+1 busy cycles, NP+2 done
        logic [15:0] sig_m  = 16'h0000;
        logic [15:0] final_m = 16'h0000;

        assign bus.start      = start_v[g];
        assign bus.golden_sig = gold_v[g];
        assign bus.dut_out    = cut_resp(cut_st, mode_v[g]);
        assign busy_v[g]      = bus.busy;
        assign done_v[g]      = bus.done;
        assign pass_v[g]      = bus.pass;
        assign dutrst_v[g]    = bus.dut_reset;
        assign din_v[g]       = bus.dut_in;
        assign sig_v[g]       = bus.signature;

        if (g == 0) begin : u_small
            seq_bist_tester #(.N_PATTERNS(NP0), .LFSR_SEED(SEED0)) dut (
                .clk(clk), .reset(rst_n), .bus(bus));
        end else begin : u_dflt
            seq_bist_tester dut (.clk(clk), .reset(rst_n), .bus(bus));
        end

        // XOR-state benchmark CUT.
        always @(posedge clk or negedge bus.dut_reset) begin
            if (!bus.dut_reset) cut_st <= 6'd0;
            else cut_st <= cut_st ^ {3'b000, bus.dut_in};
        end

        // Run timeline model.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_m <= -1;
                sig_m <= 16'h0000;
            end else if (pos_m < 0 || pos_m == NP + 2) begin
                if (start_v[g]) begin
                    pos_m   <= 0;
                    final_m <= run_sig(SEED, NP, mode_v[g]);
                end
            end else begin
                pos_m <= pos_m + 1;
                if (pos_m == 0) sig_m <= 16'h0000;
                if (pos_m == NP + 1) sig_m <= final_m;
            end
        end

        // Per-cycle comparison of all outputs against the model.
        always @(negedge clk) begin
            bit in_run, exp_done;
            in_run   = (pos_m >= 0) && (pos_m <= NP + 1);
            exp_done = (pos_m == NP + 2);
            chk("busy", g, bus.busy, in_run);
            chk("done", g, bus.done, exp_done);
            chk("dut_reset", g, bus.dut_reset, pos_m != 0);
            chk("dut_in", g, bus.dut_in,
                (pos_m >= 1 && pos_m <= NP) ? stim_at(SEED, pos_m - 1) : 3'd0);
            chk("pass", g, bus.pass, exp_done && (sig_m == gold_v[g]));
            if (pos_m <= 1 || exp_done) chk("signature", g, bus.signature, sig_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input int g);
        chk("rst_busy", g, busy_v[g], 1'b0);
        chk("rst_done", g, done_v[g], 1'b0);
        chk("rst_pass", g, pass_v[g], 1'b0);
        chk("rst_sig", g, sig_v[g], 16'h0000);
        chk("rst_dut_in", g, din_v[g], 3'd0);
        chk("rst_dut_reset", g, dutrst_v[g], 1'b1);
    endtask

    task automatic do_run(input int g, input logic [15:0] gold, input int mode, input bit noise,
                          output logic [15:0] sig_o, output int lat);
        mode_v[g]  = mode;
        gold_v[g]  = gold;
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        lat = 0;
        while (done_v[g] !== 1'b1 && lat < 300) begin
            if (noise) start_v[g] = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        start_v[g] = 1'b0;
        if (lat >= 300) chk("timeout_done", g, 32'd0, 32'd1);
        sig_o = sig_v[g];
    endtask

    initial begin
        logic [15:0] s, s_g, s_t, gold1;
        int lat;
        rst_n = 1'b0;
        start_v = 2'b00;
        gold_v[0] = 16'h0000; gold_v[1] = 16'h0000;
        mode_v[0] = 0; mode_v[1] = 0;

        chk("model_stim0", 0, stim_at(8'h01, 0), 3'd1);
        chk("model_stim1", 0, stim_at(8'h01, 1), 3'd2);
        chk("model_stim2", 0, stim_at(8'h01, 2), 3'd4);
        chk("model_stim3", 0, stim_at(8'h01, 3), 3'd0);
        chk("model_sig", 0, run_sig(8'h01, 4, 0), 16'h000D);
        chk("model_fault_sig", 0, run_sig(8'h01, 4, 1), 16'h0002);

        repeat (3) tick();
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n = 1'b1;
        repeat (2) tick();

        do_run(0, 16'h000D, 0, 1'b0, s, lat);
        chk("golden_sig", 0, s, 16'h000D);
        chk("golden_pass", 0, pass_v[0], 1'b1);
        chk("done_latency", 0, lat, 6);

        gold_v[0] = 16'h000C; #1;
        chk("wrong_golden_pass", 0, pass_v[0], 1'b0);
        chk("done_held", 0, done_v[0], 1'b1);
        gold_v[0] = 16'h000D; #1;
        chk("golden_pass_again", 0, pass_v[0], 1'b1);
        tick();

        do_run(0, 16'h000C, 0, 1'b1, s, lat);
        chk("rerun_sig", 0, s, 16'h000D);
        chk("rerun_pass", 0, pass_v[0], 1'b0);
        chk("rerun_latency", 0, lat, 6);

        do_run(0, 16'h000D, 1, 1'b1, s, lat);
        chk("fault_sig_differs", 0, s != 16'h000D, 1'b1);
        chk("fault_pass", 0, pass_v[0], 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_run(0, ($urandom_range(0, 1) == 0) ? 16'h000D : 16'($urandom),
                   int'($urandom_range(0, 2)), 1'b1, s, lat);
            repeat ($urandom_range(0, 3)) tick();
        end

        mode_v[0] = 0; gold_v[0] = 16'h000D; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1 chk_reset_vals(0);
        tick();
        rst_n = 1'b1;
        tick();
        do_run(0, 16'h000D, 0, 1'b0, s, lat);
        chk("post_reset_sig", 0, s, 16'h000D);
        chk("post_reset_pass", 0, pass_v[0], 1'b1);

        gold1 = run_sig(SEED1, NP1, 0);
        do_run(1, gold1, 0, 1'b1, s_g, lat);
        chk("dflt_golden_sig", 1, s_g, gold1);
        chk("dflt_golden_pass", 1, pass_v[1], 1'b1);
        chk("dflt_latency", 1, lat, NP1 + 2);
        do_run(1, gold1, 2, 1'b1, s_t, lat);
        chk("dflt_trojan_sig", 1, s_t, run_sig(SEED1, NP1, 2));
        chk("dflt_trojan_differs", 1, s_t != s_g, 1'b1);
        chk("dflt_trojan_pass", 1, pass_v[1], 1'b0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
